// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, ALU control codes, multiply
// sequencer state encoding and the ALU drive payload with its builders.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  // Iteration counter width; 2**CNT_W must exceed DATA_W.
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [CTRL_W-1:0] ALU_SLL = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2
  } mult_state_e;

  // Everything the sequencer presents to the shared ALU in one cycle.
  typedef struct packed {
    logic                req;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [CTRL_W-1:0]   ctrl;
    logic [SHAMT_W-1:0]  shamt;
  } alu_drive_t;

  // Quiescent drive: no request, control parked on ADD.
  function automatic alu_drive_t alu_idle();
    alu_drive_t d;
    d.req   = 1'b0;
    d.src1  = DATA_W'(0);
    d.src2  = DATA_W'(0);
    d.ctrl  = ALU_ADD;
    d.shamt = SHAMT_W'(0);
    return d;
  endfunction

  // Accumulate step: a + b.
  function automatic alu_drive_t alu_add(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    alu_drive_t d;
    d.req   = 1'b1;
    d.src1  = a;
    d.src2  = b;
    d.ctrl  = ALU_ADD;
    d.shamt = SHAMT_W'(0);
    return d;
  endfunction

  // Multiplicand doubling step: b << 1.
  function automatic alu_drive_t alu_sll1(logic [DATA_W-1:0] b);
    alu_drive_t d;
    d.req   = 1'b1;
    d.src1  = DATA_W'(0);
    d.src2  = b;
    d.ctrl  = ALU_SLL;
    d.shamt = SHAMT_W'(1);
    return d;
  endfunction

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// Request/result and shared-ALU signals of the multiply sequencer.
//   slave  : the sequencer (consumes start/operands/grant/ALU result)
//   master : the requester plus ALU arbiter side
interface alu_mult_sequencer_if;
  import alu_pkg::*;

  logic                start_i;
  logic [DATA_W-1:0]   src1_i;
  logic [DATA_W-1:0]   src2_i;
  logic                busy_o;
  logic                done_o;
  logic [DATA_W-1:0]   result_o;
  logic                alu_req_o;
  logic                alu_gnt_i;
  logic [DATA_W-1:0]   alu_src1_o;
  logic [DATA_W-1:0]   alu_src2_o;
  logic [CTRL_W-1:0]   alu_ctrl_o;
  logic [SHAMT_W-1:0]  alu_shamt_o;
  logic [DATA_W-1:0]   alu_result_i;

  modport slave (
    input  start_i, src1_i, src2_i, alu_gnt_i, alu_result_i,
    output busy_o, done_o, result_o,
    output alu_req_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o
  );

  modport master (
    output start_i, src1_i, src2_i, alu_gnt_i, alu_result_i,
    input  busy_o, done_o, result_o,
    input  alu_req_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle DATA_W x DATA_W -> low DATA_W multiply built from shift-and-add
// steps issued to the shared, combinational ALU (ADD to accumulate, SLL by 1
// to double the multiplicand). Only advances in cycles where the ALU is granted.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset; aborts any operation in flight
//   bus    : alu_mult_sequencer_if.slave (start/operands, busy/done/result,
//            ALU request/grant, ALU operands/control, ALU result)
// Configuration:
//   MULT_EARLY_EXIT_EN : when defined, finish as soon as the remaining
//                        multiplier bits are all zero (src2==0 completes in
//                        one cycle without touching the ALU).
module alu_mult_sequencer
  import alu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_mult_sequencer_if.slave   bus
);

  mult_state_e        state;
  logic [DATA_W-1:0]  mcand;
  logic [DATA_W-1:0]  mplier;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  result_q;
  alu_drive_t         drive_q;

  logic [DATA_W-1:0]  mplier_shr_c;
  logic               last_shift_c;
  logic               zero_exit_c;

  assign mplier_shr_c = mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
  assign last_shift_c = (cnt == CNT_W'(DATA_W - 1)) || (mplier_shr_c == DATA_W'(0));
  assign zero_exit_c  = (bus.src2_i == DATA_W'(0));
`else
  assign last_shift_c = (cnt == CNT_W'(DATA_W - 1));
  assign zero_exit_c  = 1'b0;
`endif

  // FSM, operand registers and registered ALU drive. The drive for the next
  // state is computed alongside the transition so the ALU sees stable,
  // registered operands for the whole step, including grant stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      drive_q  <= alu_idle();
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            mcand  <= bus.src1_i;
            mplier <= bus.src2_i;
            acc    <= '0;
            cnt    <= '0;
            if (zero_exit_c) begin
              result_q <= '0;
              done_q   <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              if (bus.src2_i[0]) begin
                state   <= ST_ADD;
                drive_q <= alu_add(DATA_W'(0), bus.src1_i);
              end else begin
                state   <= ST_SHIFT;
                drive_q <= alu_sll1(bus.src1_i);
              end
            end
          end
        end

        ST_ADD: begin
          if (bus.alu_gnt_i) begin
            acc     <= bus.alu_result_i;
            state   <= ST_SHIFT;
            drive_q <= alu_sll1(mcand);
          end
        end

        ST_SHIFT: begin
          if (bus.alu_gnt_i) begin
            mcand  <= bus.alu_result_i;
            mplier <= mplier_shr_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_shift_c) begin
              // acc already holds any ADD issued for this bit position.
              result_q <= acc;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= ST_IDLE;
              drive_q  <= alu_idle();
            end else if (mplier_shr_c[0]) begin
              state   <= ST_ADD;
              drive_q <= alu_add(acc, bus.alu_result_i);
            end else begin
              state   <= ST_SHIFT;
              drive_q <= alu_sll1(bus.alu_result_i);
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          drive_q <= alu_idle();
        end
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.result_o    = result_q;
  assign bus.alu_req_o   = drive_q.req;
  assign bus.alu_src1_o  = drive_q.src1;
  assign bus.alu_src2_o  = drive_q.src2;
  assign bus.alu_ctrl_o  = drive_q.ctrl;
  assign bus.alu_shamt_o = drive_q.shamt;

endmodule
